sfft_r4_quarter_combiner: RTL and testbench

//  Sits at the output of the shared sub-FFT core in the radix-4 sFFT chain. It is the

---
 rtl/sfft_r4_pkg.sv | 30 +++
 rtl/sfft_r4_quarter_buf.sv | 46 ++++
 rtl/sfft_r4_quarter_combiner.sv | 196 +++++++++++++++++++
 tb/tb_sfft_r4_quarter_combiner.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfft_r4_pkg.sv
// -----------------------------------------------------------------------------
// sfft_r4_pkg
//  Shared definitions for the radix-4 sFFT quarter protocol.
//  - state_t : combiner FSM encoding (FILL while quarters 0..2 are buffered,
//              MERGE while quarter 3 streams through).
//  - Q0..Q3  : quarter identifiers as carried by the 2-bit quarter counter.
//  - qlen/kw : QLEN = NFFT/4 samples per quarter, KW = bin index width,
//              both derived from SIZE_BUFFER = log2(NFFT).
// -----------------------------------------------------------------------------
package sfft_r4_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      MERGE = 1'b1
   } state_t;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   function automatic int qlen(input int size_buffer);
      return (1 << size_buffer) / 4;
   endfunction

   function automatic int kw(input int size_buffer);
      return size_buffer - 2;
   endfunction

endpackage

// File: rtl/sfft_r4_quarter_buf.sv
// -----------------------------------------------------------------------------
// sfft_r4_quarter_buf
//  One quarter of sub-FFT output: a DEPTH-entry I/Q register buffer with a
//  single synchronous write port and a combinational read port. Contents are
//  not reset; the combiner only reads entries it has written in this frame.
// Ports
//  clk        in   clock, rising edge
//  wr_en_i    in   write strobe
//  wr_addr_i  in   write bin index
//  wr_di_i    in   write sample, I
//  wr_dq_i    in   write sample, Q
//  rd_addr_i  in   read bin index
//  rd_di_o    out  read sample, I (combinational)
//  rd_dq_o    out  read sample, Q (combinational)
// -----------------------------------------------------------------------------
module sfft_r4_quarter_buf
   import sfft_r4_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int KW    = 1,
   parameter int W     = 16
) (
   input  logic          clk,
   input  logic          wr_en_i,
   input  logic [KW-1:0] wr_addr_i,
   input  logic [W-1:0]  wr_di_i,
   input  logic [W-1:0]  wr_dq_i,
   input  logic [KW-1:0] rd_addr_i,
   output logic [W-1:0]  rd_di_o,
   output logic [W-1:0]  rd_dq_o
);

   logic [W-1:0] mem_i_q [DEPTH];
   logic [W-1:0] mem_q_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_i_q[wr_addr_i] <= wr_di_i;
         mem_q_q[wr_addr_i] <= wr_dq_i;
      end
   end

   assign rd_di_o = mem_i_q[rd_addr_i];
   assign rd_dq_o = mem_q_q[rd_addr_i];

endmodule

// File: rtl/sfft_r4_quarter_combiner.sv
// -----------------------------------------------------------------------------
// sfft_r4_quarter_combiner
//  Receive end of the radix-4 quarter protocol. The sub-FFT core delivers four
//  QLEN-point quarters serially (q0, q1, q2, q3). Quarters 0..2 are buffered;
//  while quarter 3 streams in, each incoming q3[k] is registered together with
//  q0[k], q1[k], q2[k] read from the buffers, giving one aligned set per
//  accepted q3 sample with a latency of exactly one cycle. Samples pass
//  bit-exact.
// Parameters
//  SIZE_BUFFER    log2(NFFT), >= 3
//  DATA_FFT_SIZE  width of each I and Q sample
// Ports
//  clk, reset              clock; synchronous active-high reset
//  in_data_i/in_data_q     incoming sample; in_valid/in_ready handshake
//  out_d0_i..out_d3_q      bin k of quarters 0..3, registered
//  out_index               bin index k of the presented set
//  out_valid/out_ready     output handshake; set held until accepted
//  frame_done              high while the k=QLEN-1 set is being accepted
// Build option
//  SFFT_R4_FRAME_SYNC_EN   adds in_sof (forces q0[0]) and sync_err (1-cycle
//                          pulse when in_sof lands mid-frame).
// -----------------------------------------------------------------------------
module sfft_r4_quarter_combiner
   import sfft_r4_pkg::*;
#(
   parameter int SIZE_BUFFER   = 3,
   parameter int DATA_FFT_SIZE = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [DATA_FFT_SIZE-1:0]           in_data_i,
   input  logic [DATA_FFT_SIZE-1:0]           in_data_q,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic [DATA_FFT_SIZE-1:0]           out_d0_i,
   output logic [DATA_FFT_SIZE-1:0]           out_d0_q,
   output logic [DATA_FFT_SIZE-1:0]           out_d1_i,
   output logic [DATA_FFT_SIZE-1:0]           out_d1_q,
   output logic [DATA_FFT_SIZE-1:0]           out_d2_i,
   output logic [DATA_FFT_SIZE-1:0]           out_d2_q,
   output logic [DATA_FFT_SIZE-1:0]           out_d3_i,
   output logic [DATA_FFT_SIZE-1:0]           out_d3_q,
   output logic [SIZE_BUFFER-3:0]             out_index,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic                               frame_done
`ifdef SFFT_R4_FRAME_SYNC_EN
  ,input  logic                               in_sof
  ,output logic                               sync_err
`endif
);

   localparam int QLEN = qlen(SIZE_BUFFER);
   localparam int KW   = kw(SIZE_BUFFER);
   localparam logic [KW-1:0] K_LAST = KW'(QLEN - 1);

   state_t                   state_q, state_d;
   logic [1:0]               q_cnt_q, q_cnt_d;
   logic [KW-1:0]            k_cnt_q, k_cnt_d;

   logic                     out_valid_q;
   logic [KW-1:0]            out_index_q;
   logic [DATA_FFT_SIZE-1:0] od_i_q [4];
   logic [DATA_FFT_SIZE-1:0] od_q_q [4];

   logic                     xfer;
   logic                     sof_xfer;
   logic                     merge_xfer;
   logic                     k_last;
   logic [2:0]               wr_en;
   logic [KW-1:0]            wr_addr;
   logic [DATA_FFT_SIZE-1:0] rd_i [3];
   logic [DATA_FFT_SIZE-1:0] rd_q [3];

   // FILL always accepts: the output set is registered, so the next frame's
   // q0 writes can overlap a still-held final MERGE set.
   assign in_ready = (state_q == FILL) | !out_valid_q | out_ready;
   assign xfer     = in_valid & in_ready;
   assign k_last   = (k_cnt_q == K_LAST);

`ifdef SFFT_R4_FRAME_SYNC_EN
   assign sof_xfer = xfer & in_sof;
`else
   assign sof_xfer = 1'b0;
`endif

   assign merge_xfer = xfer & !sof_xfer & (state_q == MERGE);

   always_comb begin
      state_d = state_q;
      q_cnt_d = q_cnt_q;
      k_cnt_d = k_cnt_q;
      if (sof_xfer) begin
         // The sof sample itself becomes q0[0]; counting resumes at bin 1.
         k_cnt_d = KW'(1);
         q_cnt_d = Q0;
         state_d = FILL;
      end else if (xfer) begin
         if (k_last) begin
            k_cnt_d = '0;
            q_cnt_d = q_cnt_q + 2'd1;
         end else begin
            k_cnt_d = k_cnt_q + KW'(1);
         end
         if ((state_q == FILL) && (q_cnt_q == Q2) && k_last) begin
            state_d = MERGE;
         end else if ((state_q == MERGE) && k_last) begin
            state_d = FILL;
         end
      end
   end

   always_comb begin
      wr_en = '0;
      for (int n = 0; n < 3; n++) begin
         wr_en[n] = xfer & !sof_xfer & (state_q == FILL) & (q_cnt_q == 2'(n));
      end
      wr_en[0] = wr_en[0] | sof_xfer;
      wr_addr  = sof_xfer ? '0 : k_cnt_q;
   end

   for (genvar g = 0; g < 3; g++) begin : g_buf
      sfft_r4_quarter_buf #(
         .DEPTH (QLEN),
         .KW    (KW),
         .W     (DATA_FFT_SIZE)
      ) u_buf (
         .clk       (clk),
         .wr_en_i   (wr_en[g]),
         .wr_addr_i (wr_addr),
         .wr_di_i   (in_data_i),
         .wr_dq_i   (in_data_q),
         .rd_addr_i (k_cnt_q),
         .rd_di_o   (rd_i[g]),
         .rd_dq_o   (rd_q[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= FILL;
         q_cnt_q     <= Q0;
         k_cnt_q     <= '0;
         out_valid_q <= 1'b0;
         out_index_q <= '0;
         for (int n = 0; n < 4; n++) begin
            od_i_q[n] <= '0;
            od_q_q[n] <= '0;
         end
      end else begin
         state_q <= state_d;
         q_cnt_q <= q_cnt_d;
         k_cnt_q <= k_cnt_d;
         if (merge_xfer) begin
            // q3 goes straight into the output register; it is never buffered.
            out_valid_q <= 1'b1;
            out_index_q <= k_cnt_q;
            for (int n = 0; n < 3; n++) begin
               od_i_q[n] <= rd_i[n];
               od_q_q[n] <= rd_q[n];
            end
            od_i_q[3] <= in_data_i;
            od_q_q[3] <= in_data_q;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

`ifdef SFFT_R4_FRAME_SYNC_EN
   logic sync_err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_err_q <= 1'b0;
      end else begin
         sync_err_q <= sof_xfer & ((q_cnt_q != Q0) | (k_cnt_q != '0));
      end
   end

   assign sync_err = sync_err_q;
`endif

   assign out_valid  = out_valid_q;
   assign out_index  = out_index_q;
   assign out_d0_i   = od_i_q[0];
   assign out_d0_q   = od_q_q[0];
   assign out_d1_i   = od_i_q[1];
   assign out_d1_q   = od_q_q[1];
   assign out_d2_i   = od_i_q[2];
   assign out_d2_q   = od_q_q[2];
   assign out_d3_i   = od_i_q[3];
   assign out_d3_q   = od_q_q[3];
   assign frame_done = out_valid_q & out_ready & (out_index_q == K_LAST);

endmodule

// File: tb/tb_sfft_r4_quarter_combiner.sv
// -----------------------------------------------------------------------------
// tb_sfft_r4_quarter_combiner
//  Scoreboard bench for the quarter combiner at SIZE_BUFFER=5 (QLEN=8).
//  Sample j of a frame with base b carries I = b+j, Q = -(b+j); the set for
//  bin k therefore holds quarter n value b+8n+k. Expected sets are queued by
//  the driver and consumed by an independent monitor on each accepted set.
//  Build option SFFT_R4_FRAME_SYNC_EN enables the in_sof/sync_err scenario.
// -----------------------------------------------------------------------------
module tb_sfft_r4_quarter_combiner;

   localparam int SB  = 5;
   localparam int DW  = 16;
   localparam int QL  = 8;
   localparam int KWB = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] in_data_i, in_data_q;
   logic          in_valid, in_ready;
   logic [DW-1:0] out_d0_i, out_d0_q, out_d1_i, out_d1_q;
   logic [DW-1:0] out_d2_i, out_d2_q, out_d3_i, out_d3_q;
   logic [KWB-1:0] out_index;
   logic          out_valid, out_ready, frame_done;
`ifdef SFFT_R4_FRAME_SYNC_EN
   logic          in_sof, sync_err;
   int            sync_cnt = 0;
   int            sync_cyc = -1;
`endif

   sfft_r4_quarter_combiner #(
      .SIZE_BUFFER   (SB),
      .DATA_FFT_SIZE (DW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data_i  (in_data_i),
      .in_data_q  (in_data_q),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_d0_i   (out_d0_i),
      .out_d0_q   (out_d0_q),
      .out_d1_i   (out_d1_i),
      .out_d1_q   (out_d1_q),
      .out_d2_i   (out_d2_i),
      .out_d2_q   (out_d2_q),
      .out_d3_i   (out_d3_i),
      .out_d3_q   (out_d3_q),
      .out_index  (out_index),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_done (frame_done)
`ifdef SFFT_R4_FRAME_SYNC_EN
     ,.in_sof     (in_sof)
     ,.sync_err   (sync_err)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   int stall_total = 0;

   typedef struct {
      int base;
      int k;
      int cyc;
   } exp_t;

   exp_t sbq[$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic logic [63:0] iq(input int v);
      return {32'd0, 16'(v), 16'(0 - v)};
   endfunction

   // One sample; returns after the clock edge that accepted it. stamp is the
   // cycle count seen just before that edge.
   task automatic send(input logic [DW-1:0] vi, input logic [DW-1:0] vq,
                       input bit sof, output int stamp);
      int  waits;
      bit  ok;
      waits = 0;
      stamp = 0;
      @(negedge clk);
      in_valid  = 1'b1;
      in_data_i = vi;
      in_data_q = vq;
`ifdef SFFT_R4_FRAME_SYNC_EN
      in_sof    = sof;
`else
      if (sof) in_valid = 1'b1;
`endif
      forever begin
         #4;
         ok    = in_ready;
         stamp = cyc;
         @(posedge clk);
         if (ok) break;
         waits++;
         stall_total++;
         if (waits > 200) begin
            check("send_timeout", 64'(waits), 64'd0);
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic send_run(input int base, input int j0, input int j1, input bit sof_first,
                           input bit push, output int first_stamp);
      int st;
      first_stamp = 0;
      for (int j = j0; j <= j1; j++) begin
         send(16'(base + j), 16'(0 - (base + j)), sof_first && (j == j0), st);
         if (j == j0) first_stamp = st;
         if (push && j >= 3 * QL) sbq.push_back('{base, j - 3 * QL, st + 1});
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
`ifdef SFFT_R4_FRAME_SYNC_EN
      in_sof   = 1'b0;
`endif
      repeat (n) @(negedge clk);
   endtask

   // Hold the set with k=2 for three cycles and confirm the input is stalled.
   task automatic stall3(input int base);
      int t;
      t = 0;
      do begin
         @(posedge clk);
         #1;
         t++;
      end while (!(out_valid && out_index == 3'd2) && t < 600);
      if (t >= 600) begin
         check("stall_wait_timeout", 64'(t), 64'd0);
         return;
      end
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_index", 64'(out_index), 64'd2);
         check("stall_d0", 64'(out_d0_i), 64'(16'(base + 2)));
         check("stall_d3", 64'(out_d3_i), 64'(16'(base + 26)));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
   endtask

   // Monitor: consumes the scoreboard on each accepted set.
   initial begin : mon
      bit            hold_prev;
      bit            same;
      logic [DW-1:0] snap [8];
      exp_t          e;
      hold_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (reset || !out_valid) begin
            hold_prev = 1'b0;
         end else begin
            if (hold_prev) begin
               same = (out_d0_i === snap[0]) && (out_d0_q === snap[1]) &&
                      (out_d1_i === snap[2]) && (out_d1_q === snap[3]) &&
                      (out_d2_i === snap[4]) && (out_d2_q === snap[5]) &&
                      (out_d3_i === snap[6]) && (out_d3_q === snap[7]);
               check("hold_stable", 64'(same), 64'd1);
            end else if (sbq.size() == 0) begin
               check("unexpected_set", 64'(out_index), 64'hFFFF);
            end else begin
               check("latency", 64'(cyc), 64'(sbq[0].cyc));
            end
            if (out_ready && sbq.size() != 0) begin
               e = sbq.pop_front();
               check("set_q0", {32'd0, out_d0_i, out_d0_q}, iq(e.base + e.k));
               check("set_q1", {32'd0, out_d1_i, out_d1_q}, iq(e.base + QL + e.k));
               check("set_q2", {32'd0, out_d2_i, out_d2_q}, iq(e.base + 2 * QL + e.k));
               check("set_q3", {32'd0, out_d3_i, out_d3_q}, iq(e.base + 3 * QL + e.k));
               check("set_index", 64'(out_index), 64'(e.k));
               check("frame_done", 64'(frame_done), 64'(e.k == QL - 1));
            end
            hold_prev = !out_ready;
            snap[0] = out_d0_i; snap[1] = out_d0_q;
            snap[2] = out_d1_i; snap[3] = out_d1_q;
            snap[4] = out_d2_i; snap[5] = out_d2_q;
            snap[6] = out_d3_i; snap[7] = out_d3_q;
         end
      end
   end

`ifdef SFFT_R4_FRAME_SYNC_EN
   initial begin : sync_mon
      forever begin
         @(negedge clk);
         if (!reset && sync_err) begin
            sync_cnt++;
            sync_cyc = cyc;
         end
      end
   end
`endif

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t expected end", $time);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int fs, fs2, s0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data_i = '0;
      in_data_q = '0;
      out_ready = 1'b1;
`ifdef SFFT_R4_FRAME_SYNC_EN
      in_sof    = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_frame_done", 64'(frame_done), 64'd0);
      check("reset_out_index", 64'(out_index), 64'd0);
      check("reset_out_data", 64'(|{out_d0_i, out_d0_q, out_d1_i, out_d1_q,
                                    out_d2_i, out_d2_q, out_d3_i, out_d3_q}), 64'd0);
      reset = 1'b0;

      // Single frame, samples 0..31, output always ready.
      s0 = stall_total;
      send_run(0, 0, 31, 1'b0, 1'b1, fs);
      idle(4);
      check("t1_no_input_stall", 64'(stall_total - s0), 64'd0);

      // Output back-pressure at k=2.
      fork
         send_run(1000, 0, 31, 1'b0, 1'b1, fs);
         stall3(1000);
      join
      idle(4);

      // Two back-to-back frames.
      s0 = stall_total;
      send_run(2000, 0, 31, 1'b0, 1'b1, fs);
      send_run(3000, 0, 31, 1'b0, 1'b1, fs);
      idle(4);
      check("t3_no_input_stall", 64'(stall_total - s0), 64'd0);

      // Reset after 13 samples, then a clean frame.
      send_run(4000, 0, 12, 1'b0, 1'b0, fs);
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      check("t4_reset_out_valid", 64'(out_valid), 64'd0);
      check("t4_reset_in_ready", 64'(in_ready), 64'd1);
      reset = 1'b0;
      s0 = stall_total;
      send_run(5000, 0, 31, 1'b0, 1'b1, fs);
      idle(4);
      check("t4_no_input_stall", 64'(stall_total - s0), 64'd0);

`ifdef SFFT_R4_FRAME_SYNC_EN
      // in_sof on sample 5 of a frame: resync with a one-cycle error pulse.
      send_run(6000, 0, 4, 1'b0, 1'b0, fs);
      send_run(7000, 0, 31, 1'b1, 1'b1, fs2);
      idle(4);
      check("t5_sync_err_count", 64'(sync_cnt), 64'd1);
      check("t5_sync_err_cycle", 64'(sync_cyc), 64'(fs2 + 1));
      // Aligned sof on a fresh frame raises no error.
      send_run(8000, 0, 31, 1'b1, 1'b1, fs);
      idle(4);
      check("t5_aligned_sof_no_err", 64'(sync_cnt), 64'd1);
`endif

      check("scoreboard_drained", 64'(sbq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
